fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the single-cycle datapath. It owns the fetch PC and issues word-aligned requests on the instruction-memory bus. It buffers returned instruction words in a small prefetch FIFO and presents them, with their PC, to the datapath over a valid/ready handshake. On a taken branch or jump, the datapath redirects it, and the block discards all stale in-flight and buffered instructions.

---
 rtl/fetch_unit.sv | 114 +++++++++++
 tb/tb_fetch_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues word requests under a credit limit,
// buffers returned words with their PC and hands them to the datapath; redirects flush stale work.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = AW + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  logic [31:0]   r_fetchPc;
  logic          r_active;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop;
  logic [CW-1:0] r_wrPtr;
  logic [CW-1:0] r_rdPtr;
  logic [CW-1:0] r_tagWrPtr;
  logic [CW-1:0] r_tagRdPtr;
  logic [31:0]   r_dataMem [DEPTH];
  logic [31:0]   r_pcMem   [DEPTH];
  logic [31:0]   r_tagMem  [DEPTH];
  logic [31:0]   r_holdInst;
  logic [31:0]   r_holdPc;

  logic [CW-1:0] w_count;
  logic [CW:0]   w_used;
  logic          w_empty;
  logic          w_reqFire;
  logic          w_rspFire;
  logic          w_rspKeep;
  logic          w_pop;
  logic [CW-1:0] w_outNext;
  logic [31:0]   w_headInst;
  logic [31:0]   w_headPc;

  assign w_count    = r_wrPtr - r_rdPtr;
  assign w_used     = {1'b0, r_outstanding} + {1'b0, w_count};
  assign w_empty    = (r_wrPtr == r_rdPtr);
  assign w_headInst = r_dataMem[r_rdPtr[AW-1:0]];
  assign w_headPc   = r_pcMem[r_rdPtr[AW-1:0]];

  // r_active keeps the request line low until the first edge after reset release.
  assign imem_req_valid = r_active && (w_used < LIMIT);
  assign imem_req_addr  = r_fetchPc;
  assign w_reqFire      = imem_req_valid && imem_req_ready;
  // Responses with nothing outstanding are leftovers from before a reset.
  assign w_rspFire      = imem_rsp_valid && (r_outstanding != '0);
  assign w_rspKeep      = w_rspFire && (r_drop == '0) && !redirect;
  assign w_outNext      = r_outstanding + CW'(w_reqFire) - CW'(w_rspFire);

  assign inst_valid = !w_empty && !redirect;
  assign w_pop      = inst_valid && inst_ready;
  assign inst       = w_empty ? r_holdInst : w_headInst;
  assign inst_pc    = w_empty ? r_holdPc   : w_headPc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetchPc     <= RESET_PC;
      r_active      <= 1'b0;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_wrPtr       <= '0;
      r_rdPtr       <= '0;
      r_tagWrPtr    <= '0;
      r_tagRdPtr    <= '0;
      r_holdInst    <= '0;
      r_holdPc      <= '0;
    end else begin
      r_active      <= 1'b1;
      r_outstanding <= w_outNext;
      if (w_reqFire) r_tagWrPtr <= r_tagWrPtr + CW'(1);
      if (w_rspFire) r_tagRdPtr <= r_tagRdPtr + CW'(1);
      if (!w_empty) begin
        r_holdInst <= w_headInst;
        r_holdPc   <= w_headPc;
      end
      // A redirect overrides the PC step, FIFO traffic and drop bookkeeping of this cycle.
      if (redirect) begin
        r_fetchPc <= redirect_pc & 32'hFFFF_FFFC;
        r_rdPtr   <= r_wrPtr;
        r_drop    <= w_outNext;
      end else begin
        if (w_reqFire) r_fetchPc <= r_fetchPc + 32'd4;
        if (w_rspFire && (r_drop != '0)) r_drop <= r_drop - CW'(1);
        if (w_rspKeep) r_wrPtr <= r_wrPtr + CW'(1);
        if (w_pop) r_rdPtr <= r_rdPtr + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_reqFire) r_tagMem[r_tagWrPtr[AW-1:0]] <= r_fetchPc;
    if (w_rspKeep) begin
      r_dataMem[r_wrPtr[AW-1:0]] <= imem_rsp_data;
      r_pcMem[r_wrPtr[AW-1:0]]   <= r_tagMem[r_tagRdPtr[AW-1:0]];
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: a latency-programmable memory model feeds the DUT and a
// scoreboard of expected fetch PCs checks every instruction handed to the datapath.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } memReq_t;

  memReq_t     pending[$];
  logic [31:0] expQ[$];
  logic [31:0] expAddr;
  logic [31:0] lastPc;
  int          cyc;
  int          memLat;
  int          reqCount;
  int          checks;
  int          failures;
  logic        sampInstValid;
  logic        lastFired;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h5A17};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: entered at posedge+1, drives memory and redirect, scores at the negedge.
  // mode 0 = no redirect, 1 = redirect, 2 = redirect only if a handshake and a response coincide.
  task automatic applyStimulus(input int mode, input logic [31:0] rpc);
    logic [31:0] e;
    if (pending.size() > 0 && pending[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memWord(pending[0].addr);
      void'(pending.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    lastFired = 1'b0;
    if (mode == 1 || (mode == 2 && imem_rsp_valid && imem_req_valid && imem_req_ready)) begin
      redirect    = 1'b1;
      redirect_pc = rpc;
      lastFired   = 1'b1;
    end
    #4;
    sampInstValid = inst_valid;
    if (redirect) checkOutput("redirInstValid", 32'(inst_valid), 32'd0);
    if (imem_req_valid && imem_req_ready) begin
      checkOutput("reqAddr", imem_req_addr, expAddr);
      pending.push_back('{addr: imem_req_addr, due: cyc + memLat});
      if (!redirect) expQ.push_back(expAddr);
      expAddr = expAddr + 32'd4;
      reqCount++;
    end
    if (inst_valid && inst_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("spuriousInst", 32'(inst_valid), 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("instPc", inst_pc, e);
        checkOutput("instWord", inst, memWord(e));
        lastPc = e;
      end
    end
    if (redirect) begin
      expQ.delete();
      expAddr = rpc & 32'hFFFF_FFFC;
    end
    @(posedge clk);
    #1;
    redirect = 1'b0;
    cyc++;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 32'd0);
  endtask

  // Stops issuing and lets everything in flight and buffered reach the datapath.
  task automatic drain(input int maxCyc);
    imem_req_ready = 1'b0;
    inst_ready     = 1'b1;
    for (int i = 0; i < maxCyc; i++) begin
      if (expQ.size() == 0 && pending.size() == 0) break;
      applyStimulus(0, 32'd0);
    end
    runCycles(2);
    checkOutput("drainExpQ", 32'(expQ.size()), 32'd0);
  endtask

  task automatic checkResetOutputs(input string tagPrefix);
    checkOutput({tagPrefix, "ReqValid"}, 32'(imem_req_valid), 32'd0);
    checkOutput({tagPrefix, "ReqAddr"}, imem_req_addr, RST_PC);
    checkOutput({tagPrefix, "InstValid"}, 32'(inst_valid), 32'd0);
    checkOutput({tagPrefix, "Inst"}, inst, 32'd0);
    checkOutput({tagPrefix, "InstPc"}, inst_pc, 32'd0);
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; reqCount = 0; memLat = 1;
    expAddr = RST_PC; lastPc = '0; lastFired = 1'b0; sampInstValid = 1'b0;
    rst_n = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;

    #12;
    checkResetOutputs("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(0, 32'd0);

    // Backpressure straight out of reset: only DEPTH requests fit.
    reqCount = 0;
    runCycles(10);
    checkOutput("bpReqCount", 32'(reqCount), 32'(DEPTH));
    checkOutput("bpReqValid", 32'(imem_req_valid), 32'd0);
    inst_ready = 1'b1;
    runCycles(30);
    drain(20);

    // Redirect with two fetches in flight at latency 3.
    memLat = 3; imem_req_ready = 1'b1; inst_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (pending.size() == 2) break;
      applyStimulus(0, 32'd0);
    end
    checkOutput("inflightTwo", 32'(pending.size()), 32'd2);
    applyStimulus(1, 32'h0000_0400);
    runCycles(20);
    drain(30);

    // Redirect coinciding with a handshake, a response and inst_ready.
    memLat = 1; imem_req_ready = 1'b1; inst_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(2, 32'h0000_0800);
      if (lastFired) break;
    end
    checkOutput("simulFired", 32'(lastFired), 32'd1);
    runCycles(15);
    drain(20);

    // Unaligned redirect near the top of the address space wraps to zero.
    imem_req_ready = 1'b1;
    applyStimulus(1, 32'hFFFF_FFFE);
    runCycles(12);
    drain(20);
    checkOutput("holdInstValid", 32'(inst_valid), 32'd0);
    checkOutput("holdInstPc", inst_pc, lastPc);
    checkOutput("holdInst", inst, memWord(lastPc));

    // Asynchronous reset with one fetch in flight and a buffered word.
    memLat = 3; imem_req_ready = 1'b1; inst_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (pending.size() == 1 && inst_valid) break;
      applyStimulus(0, 32'd0);
    end
    checkOutput("preRstInflight", 32'(pending.size()), 32'd1);
    checkOutput("preRstValid", 32'(inst_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    imem_rsp_valid = 1'b0;
    #1;
    checkResetOutputs("midRst");
    expQ.delete();
    expAddr = RST_PC;
    memLat = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    inst_ready = 1'b1;
    if (pending.size() > 0) pending[0].due = cyc + 1;
    checkOutput("relIdle", 32'(imem_req_valid), 32'd0);
    applyStimulus(0, 32'd0);
    checkOutput("restartValid", 32'(imem_req_valid), 32'd1);
    checkOutput("restartAddr", imem_req_addr, RST_PC);
    applyStimulus(0, 32'd0);
    checkOutput("lat1", 32'(sampInstValid), 32'd0);
    applyStimulus(0, 32'd0);
    checkOutput("lat2", 32'(sampInstValid), 32'd0);
    applyStimulus(0, 32'd0);
    checkOutput("lat3", 32'(sampInstValid), 32'd1);
    runCycles(10);
    drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
